// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline constants, instruction field positions and IF/ID entry type
package riscv_pipe_pkg;

    localparam int          PKG_XLEN = 32;
    localparam logic [31:0] RV_NOP   = 32'h0000_0013;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;
    localparam int REG_W   = 5;
    localparam int OPC_W   = 7;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [31:0]         instr;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_fifo_mem.sv
// rtl/ifid_fifo_mem.sv - DEPTH x WIDTH register array, one write port, async read by address
module ifid_fifo_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Cleared on reset so the read port never presents X, even before first write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ifid_buffer.sv
// rtl/ifid_buffer.sv - elastic IF/ID buffer with flush and decoded register fields; IFID_PERF_CNT_EN adds stall/flush counters
module ifid_buffer
    import riscv_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [31:0]     out_instr,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [6:0]      out_opcode
`ifdef IFID_PERF_CNT_EN
   ,output logic [31:0]     perf_stall_cnt
   ,output logic [31:0]     perf_flush_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = XLEN + 32;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic [EW-1:0] head_raw;
    logic [XLEN-1:0] head_pc;
    logic [31:0]     head_instr;

    // Ready depends on registered count only, so a full buffer refuses a push even when ID pops.
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);

    // The in-flight fetch during a flush is wrong-path and must be dropped with everything else.
    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    ifid_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (PW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({in_pc, in_instr}),
        .rd_addr (rd_ptr),
        .rd_data (head_raw)
    );

    assign head_pc    = head_raw[EW-1:32];
    assign head_instr = head_raw[31:0];

    // An empty buffer presents a NOP at PC 0 so decode never sees stale or X payload.
    assign out_pc       = out_valid ? head_pc : '0;
    assign out_instr    = out_valid ? head_instr : RV_NOP;
    assign out_pc_plus4 = out_pc + XLEN'(4);
    assign out_rs1      = out_instr[RS1_LSB +: REG_W];
    assign out_rs2      = out_instr[RS2_LSB +: REG_W];
    assign out_rd       = out_instr[RD_LSB +: REG_W];
    assign out_opcode   = out_instr[OPC_W-1:0];

`ifdef IFID_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && perf_stall_cnt != 32'hFFFF_FFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush && out_valid && perf_flush_cnt != 32'hFFFF_FFFF) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`else
    // Counters are not built; the datapath above is unaffected.
`endif

endmodule
